// File: rtl/serial_adder_sub.sv
// Multi-cycle adder/subtractor: consumes operands LSB-first, BITS_PER_CYCLE bits per clock,
// with the carry registered between slices and a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start, outputs hold last result
// RUN   | one slice added per clock, slice counter counts down to zero
// DONE  | single-cycle completion; start here begins the next operation back-to-back
module serial_adder_sub #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int B  = BITS_PER_CYCLE;
    localparam int N  = (B > 0) ? WIDTH / B : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 1 || B < 1 || (WIDTH % B) != 0) begin : g_bad_param
        $error("serial_adder_sub: BITS_PER_CYCLE must be >= 1 and divide WIDTH");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [B:0]         slice_total;
    logic               carry_msb;
    logic [WIDTH+B-1:0] res_cat;
    logic [WIDTH-1:0]   res_next;
    logic               accept;

    assign slice_total = {1'b0, a_reg[B-1:0]} + {1'b0, b_reg[B-1:0]} + (B+1)'(carry);
    // Carry into the slice's top full adder; on the last slice this is the carry into the MSB.
    assign carry_msb   = a_reg[B-1] ^ b_reg[B-1] ^ slice_total[B-1];
    assign res_cat     = {slice_total[B-1:0], res};
    assign res_next    = res_cat[WIDTH+B-1:B];
    assign accept      = start && (state != RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            res      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            // Subtract runs as a + ~b + ~c_in, i.e. a - b - c_in.
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub ? ~c_in : c_in;
            cnt   <= CW'(N - 1);
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    a_reg <= a_reg >> B;
                    b_reg <= b_reg >> B;
                    carry <= slice_total[B];
                    res   <= res_next;
                    if (cnt == '0) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sum      <= res_next;
                        c_out    <= slice_total[B];
                        overflow <= slice_total[B] ^ carry_msb;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_sub.sv
// Bench for serial_adder_sub: three parameter sets side by side, fixed vectors,
// handshake/reset corner sequences and random operations against an arithmetic model.
module tb_serial_adder_sub;

    logic       clk;
    logic       rst_n;
    logic [2:0] start_v;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic       sub;
    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic [2:0] co_v;
    logic [2:0] ov_v;
    logic       sum1;
    logic [7:0] sum8;
    logic [7:0] sum4;

    int n_cmp = 0;
    int n_bad = 0;

    // id 0: WIDTH=1,B=1   id 1: WIDTH=8,B=1   id 2: WIDTH=8,B=4
    serial_adder_sub #(.WIDTH(1), .BITS_PER_CYCLE(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a[0:0]), .b(b[0:0]),
        .c_in(c_in), .sub(sub), .busy(busy_v[0]), .done(done_v[0]), .sum(sum1),
        .c_out(co_v[0]), .overflow(ov_v[0]));

    serial_adder_sub #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_w8b1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a), .b(b),
        .c_in(c_in), .sub(sub), .busy(busy_v[1]), .done(done_v[1]), .sum(sum8),
        .c_out(co_v[1]), .overflow(ov_v[1]));

    serial_adder_sub #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_w8b4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a), .b(b),
        .c_in(c_in), .sub(sub), .busy(busy_v[2]), .done(done_v[2]), .sum(sum4),
        .c_out(co_v[2]), .overflow(ov_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       su;
        logic [7:0] exp_sum;
        logic       exp_co;
        logic       exp_ov;
        int         exp_lat;
    } vec_t;

    function automatic int width_of(input int id);
        return (id == 0) ? 1 : 8;
    endfunction

    function automatic int lat_of(input int id);
        case (id)
            0:       return 1;
            1:       return 8;
            default: return 2;
        endcase
    endfunction

    function automatic logic [7:0] get_sum(input int id);
        case (id)
            0:       return {7'b0, sum1};
            1:       return sum8;
            default: return sum4;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on W-bit operands; overflow from signed range.
    task automatic ref_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input logic su,
                          output logic [7:0] s, output logic co, output logic ov);
        int mask, ua, ub, sa, sb, tot, v;
        mask = (1 << w) - 1;
        ua   = int'(av) & mask;
        ub   = int'(bv) & mask;
        tot  = su ? (ua - ub - int'(ci) + (1 << w)) : (ua + ub + int'(ci));
        s    = 8'(tot & mask);
        co   = (tot >> w) != 0;
        sa   = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb   = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        v    = su ? (sa - sb - int'(ci)) : (sa + sb + int'(ci));
        ov   = (v < -(1 << (w - 1))) || (v > (1 << (w - 1)) - 1);
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic start_op(input int id, input logic [7:0] av, input logic [7:0] bv,
                            input logic ci, input logic su);
        a = av; b = bv; c_in = ci; sub = su;
        start_v[id] = 1'b1;
        @(negedge clk);
        start_v[id] = 1'b0;
    endtask

    task automatic wait_done(input int id, output int n);
        n = 0;
        while (!done_v[id] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {31'b0, done_v[id]}, 32'd1);
    endtask

    vec_t vecs[13];
    int   lat;
    logic [7:0] es;
    logic eco, eov;
    logic [7:0] prev_sum;
    logic [7:0] ra, rb;
    logic rci, rsu;

    initial begin
        vecs[0]  = '{0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1};
        vecs[1]  = '{0, 8'd0, 8'd0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 1};
        vecs[2]  = '{0, 8'd0, 8'd1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1};
        vecs[3]  = '{0, 8'd0, 8'd1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1};
        vecs[4]  = '{0, 8'd1, 8'd0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1};
        vecs[5]  = '{0, 8'd1, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1};
        vecs[6]  = '{0, 8'd1, 8'd1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1};
        vecs[7]  = '{0, 8'd1, 8'd1, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0, 1};
        vecs[8]  = '{1, 8'd200, 8'd100, 1'b0, 1'b0, 8'd44, 1'b1, 1'b0, 8};
        vecs[9]  = '{1, 8'd127, 8'd1, 1'b0, 1'b0, 8'd128, 1'b0, 1'b1, 8};
        vecs[10] = '{1, 8'd5, 8'd7, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 8};
        vecs[11] = '{1, 8'h80, 8'd1, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 8};
        vecs[12] = '{2, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 2};

        rst_n = 1'b0; start_v = '0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int id = 0; id < 3; id++) begin
            chk("reset_busy", {29'b0, busy_v}, 32'd0);
            chk("reset_done", {29'b0, done_v}, 32'd0);
            chk("reset_sum", {24'b0, get_sum(id)}, 32'd0);
            chk("reset_flags", {26'b0, co_v, ov_v}, 32'd0);
        end

        for (int i = 0; i < 13; i++) begin
            start_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].su);
            chk("vec_busy", {31'b0, busy_v[vecs[i].id]}, 32'd1);
            wait_done(vecs[i].id, lat);
            chk("vec_lat", lat, vecs[i].exp_lat);
            chk("vec_sum", {24'b0, get_sum(vecs[i].id)}, {24'b0, vecs[i].exp_sum});
            chk("vec_cout", {31'b0, co_v[vecs[i].id]}, {31'b0, vecs[i].exp_co});
            chk("vec_ovf", {31'b0, ov_v[vecs[i].id]}, {31'b0, vecs[i].exp_ov});
            @(negedge clk);
            chk("vec_done_pulse", {31'b0, done_v[vecs[i].id]}, 32'd0);
        end

        // start pulsed mid-RUN must be ignored
        start_op(1, 8'd10, 8'd20, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        start_op(1, 8'd99, 8'd99, 1'b1, 1'b1);
        wait_done(1, lat);
        chk("ignored_lat", lat + 3, 32'd8);
        chk("ignored_sum", {24'b0, sum8}, 32'd30);
        @(negedge clk);
        @(negedge clk);
        chk("ignored_not_queued", {31'b0, busy_v[1]}, 32'd0);

        // back-to-back through DONE
        start_op(1, 8'd50, 8'd60, 1'b1, 1'b0);
        wait_done(1, lat);
        chk("b2b_first_sum", {24'b0, sum8}, 32'd111);
        start_op(1, 8'd100, 8'd30, 1'b0, 1'b1);
        chk("b2b_busy", {31'b0, busy_v[1]}, 32'd1);
        chk("b2b_done_low", {31'b0, done_v[1]}, 32'd0);
        chk("b2b_hold_sum", {24'b0, sum8}, 32'd111);
        wait_done(1, lat);
        chk("b2b_lat", lat, 32'd8);
        chk("b2b_second_sum", {24'b0, sum8}, 32'd70);
        chk("b2b_second_cout", {31'b0, co_v[1]}, 32'd1);
        @(negedge clk);

        // asynchronous reset mid-RUN
        start_op(1, 8'd200, 8'd100, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'b0, busy_v[1]}, 32'd0);
        chk("rst_sum", {24'b0, sum8}, 32'd0);
        chk("rst_flags", {30'b0, co_v[1], ov_v[1]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done_v[1]) chk("rst_no_done", {31'b0, done_v[1]}, 32'd0);
        end
        start_op(1, 8'd3, 8'd4, 1'b0, 1'b0);
        wait_done(1, lat);
        chk("post_rst_lat", lat, 32'd8);
        chk("post_rst_sum", {24'b0, sum8}, 32'd7);
        @(negedge clk);

        // random operations on every configuration
        for (int id = 0; id < 3; id++) begin
            for (int k = 0; k < 25; k++) begin
                ra  = 8'($urandom);
                rb  = 8'($urandom);
                rci = 1'($urandom);
                rsu = 1'($urandom);
                ref_op(width_of(id), ra, rb, rci, rsu, es, eco, eov);
                start_op(id, ra, rb, rci, rsu);
                a = 8'($urandom); b = 8'($urandom);
                wait_done(id, lat);
                chk("rand_lat", lat, lat_of(id));
                chk("rand_sum", {24'b0, get_sum(id)}, {24'b0, es});
                chk("rand_cout", {31'b0, co_v[id]}, {31'b0, eco});
                chk("rand_ovf", {31'b0, ov_v[id]}, {31'b0, eov});
                @(negedge clk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
